// File: rtl/audio_pkg.sv
// Shared audio sample definitions: sample width, stereo-to-mono mix and
// magnitude helper used by the record capture path.
package audio_pkg;

    localparam int unsigned SAMPLE_W = 16;

    // Floor of the average of two signed samples. The 17-bit sum cannot overflow.
    function automatic logic [SAMPLE_W-1:0] mono_mix(input logic [SAMPLE_W-1:0] left,
                                                     input logic [SAMPLE_W-1:0] right);
        logic [SAMPLE_W:0] sum;
        sum = {left[SAMPLE_W-1], left} + {right[SAMPLE_W-1], right};
        return sum[SAMPLE_W:1];
    endfunction

    // Magnitude of a signed sample, saturating the most negative value to 0x7FFF.
    function automatic logic [SAMPLE_W-2:0] abs_sat(input logic [SAMPLE_W-1:0] sample);
        logic [SAMPLE_W-1:0] mag;
        if (sample == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
            return {(SAMPLE_W-1){1'b1}};
        end
        mag = sample[SAMPLE_W-1] ? (~sample + 1'b1) : sample;
        return mag[SAMPLE_W-2:0];
    endfunction

endpackage

// File: rtl/ac97_record_capture_if.sv
// Mono sample stream leaving the record capture block (valid/ready).
interface ac97_record_capture_if;
    import audio_pkg::*;

    logic [SAMPLE_W-1:0] out_sample;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output out_sample,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_sample,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO with extra-MSB pointers; a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module sample_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [ADDR_W:0]  wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                     (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = wr_ptr_q - rd_ptr_q;
    // Head reads as zero while empty so the output is clean out of reset.
    assign head    = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/ac97_record_capture.sv
// AC97 record capture: mono mix, decimation by DECIM and FIFO buffering.
// Optional peak-magnitude hold is enabled by defining RECORD_PEAK_HOLD_EN.
module ac97_record_capture
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned DECIM = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    new_frame,
    input  logic [SAMPLE_W-1:0]     rec_left,
    input  logic [SAMPLE_W-1:0]     rec_right,
    ac97_record_capture_if.master   out_if,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    input  logic                    clear_ovf
`ifdef RECORD_PEAK_HOLD_EN
    ,
    input  logic                    peak_clear,
    output logic [SAMPLE_W-2:0]     peak
`endif
);

    localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [CNT_W-1:0]    dcnt_q, dcnt_d;
    logic                pend_q, pend_d;
    logic [SAMPLE_W-1:0] pend_sample_q, pend_sample_d;
    logic                ovf_q, ovf_d;
    logic                fifo_full, fifo_empty;
    logic                drop;

    always_comb begin
        dcnt_d        = dcnt_q;
        pend_d        = 1'b0;
        pend_sample_d = pend_sample_q;
        if (!enable) begin
            dcnt_d = '0;
        end else if (new_frame) begin
            if (dcnt_q == '0) begin
                pend_d        = 1'b1;
                pend_sample_d = mono_mix(rec_left, rec_right);
            end
            dcnt_d = (dcnt_q == CNT_W'(DECIM - 1)) ? '0 : dcnt_q + 1'b1;
        end
    end

    // A full FIFO always has a head, so out_ready alone means a pop frees a slot.
    assign drop  = pend_q && fifo_full && !out_if.out_ready;
    assign ovf_d = drop || (ovf_q && !clear_ovf);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dcnt_q        <= '0;
            pend_q        <= 1'b0;
            pend_sample_q <= '0;
            ovf_q         <= 1'b0;
        end else begin
            dcnt_q        <= dcnt_d;
            pend_q        <= pend_d;
            pend_sample_q <= pend_sample_d;
            ovf_q         <= ovf_d;
        end
    end

    assign overflow         = ovf_q;
    assign out_if.out_valid = !fifo_empty;

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (pend_q),
        .push_data (pend_sample_q),
        .pop       (out_if.out_ready),
        .head      (out_if.out_sample),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

`ifdef RECORD_PEAK_HOLD_EN
    logic [SAMPLE_W-2:0] peak_q, peak_d, mag;
    logic                write_ok;

    assign mag      = abs_sat(pend_sample_q);
    assign write_ok = pend_q && !drop;

    always_comb begin
        peak_d = peak_q;
        if (peak_clear) begin
            peak_d = write_ok ? mag : '0;
        end else if (write_ok && (mag > peak_q)) begin
            peak_d = mag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`endif

endmodule
